tree_space_arbiter: RTL and testbench

TREE_SPACE_ARBITER -- requirements
Module: tree_space_arbiter

---
 rtl/tree_space_arbiter.sv | 224 ++++++++++++++++++++++
 tb/tb_tree_space_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tree_space_arbiter.sv
// Shares one tree-RAM space manager between NB_REQ requesters: independent
// round-robin arbiters for node allocation and node release, plus an in-use counter.
module tree_space_arbiter #(
  parameter int RAM_ADDR_WIDTH = 16,
  parameter int NB_REQ         = 2,
  localparam int IDX_W         = (NB_REQ > 1) ? $clog2(NB_REQ) : 1
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  // allocation requesters
  input  logic [NB_REQ-1:0]                req_valid,
  output logic [NB_REQ-1:0]                req_ready,
  output logic [RAM_ADDR_WIDTH-1:0]        req_addr,
  // release requesters
  input  logic [NB_REQ-1:0]                free_valid,
  output logic [NB_REQ-1:0]                free_ready,
  input  logic [NB_REQ*RAM_ADDR_WIDTH-1:0] free_addr,
  // space manager allocation channel
  output logic                             mgr_req_valid,
  input  logic                             mgr_req_ready,
  input  logic [RAM_ADDR_WIDTH-1:0]        mgr_req_addr,
  // space manager release channel
  output logic                             mgr_free_valid,
  input  logic                             mgr_free_ready,
  output logic [RAM_ADDR_WIDTH-1:0]        mgr_free_addr,
  input  logic                             mgr_full,
  // status
  output logic [RAM_ADDR_WIDTH:0]          used_count,
  output logic                             free_err,
  // debug visibility of both arbiters
  output logic                             dbg_alloc_state_o,
  output logic [IDX_W-1:0]                 dbg_alloc_ptr_o,
  output logic                             dbg_free_state_o,
  output logic [IDX_W-1:0]                 dbg_free_ptr_o
);

  // Handshake: a transfer happens in the cycle where a valid and its ready are
  // both high; the requester-side ready is a combinational copy of the manager
  // ready, gated to the current grantee, so it pulses only in that cycle.

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  localparam logic [RAM_ADDR_WIDTH:0] USED_MAX = {1'b1, {RAM_ADDR_WIDTH{1'b0}}};

  // First set bit of v at or after p, wrapping modulo NB_REQ.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NB_REQ-1:0] v,
                                               input logic [IDX_W-1:0]  p);
    logic           found;
    logic [IDX_W-1:0] sel;
    int             idx;
    found = 1'b0;
    sel   = p;
    for (int i = 0; i < NB_REQ; i++) begin
      idx = (int'(p) + i) % NB_REQ;
      if (!found && v[idx]) begin
        found = 1'b1;
        sel   = IDX_W'(idx);
      end
    end
    return sel;
  endfunction

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] g);
    if (int'(g) == NB_REQ - 1) return '0;
    return g + 1'b1;
  endfunction

  // ---------------------------------------------------------------------------
  // Allocation arbiter
  // ---------------------------------------------------------------------------
  state_e           a_state_q, a_state_d;
  logic [IDX_W-1:0] a_grant_q, a_grant_d;
  logic [IDX_W-1:0] a_ptr_q,   a_ptr_d;
  logic             a_gnt_valid;
  logic             a_xfer;

  assign a_gnt_valid = req_valid[a_grant_q];
  assign a_xfer      = (a_state_q == ST_GRANT) && a_gnt_valid && mgr_req_ready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      a_state_q <= ST_IDLE;
      a_grant_q <= '0;
      a_ptr_q   <= '0;
    end else begin
      a_state_q <= a_state_d;
      a_grant_q <= a_grant_d;
      a_ptr_q   <= a_ptr_d;
    end
  end

  always_comb begin
    a_state_d = a_state_q;
    a_grant_d = a_grant_q;
    a_ptr_d   = a_ptr_q;
    case (a_state_q)
      ST_IDLE: begin
        // A full manager blocks new grants; an existing grant is not revoked.
        if ((|req_valid) && !mgr_full) begin
          a_grant_d = rr_pick(req_valid, a_ptr_q);
          a_state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (a_xfer) begin
          a_state_d = ST_IDLE;
          a_ptr_d   = next_idx(a_grant_q);
        end else if (!a_gnt_valid) begin
          a_state_d = ST_IDLE;
        end
      end
      default: a_state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mgr_req_valid = 1'b0;
    req_ready     = '0;
    if (a_state_q == ST_GRANT) begin
      mgr_req_valid        = a_gnt_valid;
      req_ready[a_grant_q] = a_xfer;
    end
  end

  assign req_addr = mgr_req_addr;

  // ---------------------------------------------------------------------------
  // Release arbiter
  // ---------------------------------------------------------------------------
  state_e           f_state_q, f_state_d;
  logic [IDX_W-1:0] f_grant_q, f_grant_d;
  logic [IDX_W-1:0] f_ptr_q,   f_ptr_d;
  logic             f_gnt_valid;
  logic             f_xfer;

  assign f_gnt_valid = free_valid[f_grant_q];
  assign f_xfer      = (f_state_q == ST_GRANT) && f_gnt_valid && mgr_free_ready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      f_state_q <= ST_IDLE;
      f_grant_q <= '0;
      f_ptr_q   <= '0;
    end else begin
      f_state_q <= f_state_d;
      f_grant_q <= f_grant_d;
      f_ptr_q   <= f_ptr_d;
    end
  end

  always_comb begin
    f_state_d = f_state_q;
    f_grant_d = f_grant_q;
    f_ptr_d   = f_ptr_q;
    case (f_state_q)
      ST_IDLE: begin
        if (|free_valid) begin
          f_grant_d = rr_pick(free_valid, f_ptr_q);
          f_state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (f_xfer) begin
          f_state_d = ST_IDLE;
          f_ptr_d   = next_idx(f_grant_q);
        end else if (!f_gnt_valid) begin
          f_state_d = ST_IDLE;
        end
      end
      default: f_state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mgr_free_valid = 1'b0;
    mgr_free_addr  = '0;
    free_ready     = '0;
    if (f_state_q == ST_GRANT) begin
      mgr_free_valid        = f_gnt_valid;
      mgr_free_addr         = free_addr[int'(f_grant_q)*RAM_ADDR_WIDTH +: RAM_ADDR_WIDTH];
      free_ready[f_grant_q] = f_xfer;
    end
  end

  // ---------------------------------------------------------------------------
  // In-use node counter and release-underflow flag
  // ---------------------------------------------------------------------------
  logic [RAM_ADDR_WIDTH:0] used_q, used_d;
  logic                    err_q,  err_d;

  always_comb begin
    used_d = used_q;
    err_d  = err_q;
    if (a_xfer && !f_xfer) begin
      if (used_q != USED_MAX) used_d = used_q + 1'b1;
    end else if (f_xfer && !a_xfer) begin
      // Releasing with nothing allocated is a requester bug; remember it.
      if (used_q != '0) used_d = used_q - 1'b1;
      else              err_d  = 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      used_q <= '0;
      err_q  <= 1'b0;
    end else begin
      used_q <= used_d;
      err_q  <= err_d;
    end
  end

  assign used_count = used_q;
  assign free_err   = err_q;

  assign dbg_alloc_state_o = a_state_q;
  assign dbg_alloc_ptr_o   = a_ptr_q;
  assign dbg_free_state_o  = f_state_q;
  assign dbg_free_ptr_o    = f_ptr_q;

endmodule

// File: tb/tb_tree_space_arbiter.sv
// Directed bench for tree_space_arbiter: round-robin allocation, full stall,
// abandoned grant, simultaneous transfers, release underflow and async reset.
module tb_tree_space_arbiter;
  localparam int W = 16;
  localparam int N = 2;

  logic           aclk;
  logic           aresetn;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   req_addr;
  logic [N-1:0]   free_valid;
  logic [N-1:0]   free_ready;
  logic [N*W-1:0] free_addr;
  logic           mgr_req_valid;
  logic           mgr_req_ready;
  logic [W-1:0]   mgr_req_addr;
  logic           mgr_free_valid;
  logic           mgr_free_ready;
  logic [W-1:0]   mgr_free_addr;
  logic           mgr_full;
  logic [W:0]     used_count;
  logic           free_err;
  logic           dbg_alloc_state_o;
  logic [0:0]     dbg_alloc_ptr_o;
  logic           dbg_free_state_o;
  logic [0:0]     dbg_free_ptr_o;

  int vectors     = 0;
  int miscompares = 0;

  tree_space_arbiter #(.RAM_ADDR_WIDTH(W), .NB_REQ(N)) dut (
    .aclk              (aclk),
    .aresetn           (aresetn),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_addr          (req_addr),
    .free_valid        (free_valid),
    .free_ready        (free_ready),
    .free_addr         (free_addr),
    .mgr_req_valid     (mgr_req_valid),
    .mgr_req_ready     (mgr_req_ready),
    .mgr_req_addr      (mgr_req_addr),
    .mgr_free_valid    (mgr_free_valid),
    .mgr_free_ready    (mgr_free_ready),
    .mgr_free_addr     (mgr_free_addr),
    .mgr_full          (mgr_full),
    .used_count        (used_count),
    .free_err          (free_err),
    .dbg_alloc_state_o (dbg_alloc_state_o),
    .dbg_alloc_ptr_o   (dbg_alloc_ptr_o),
    .dbg_free_state_o  (dbg_free_state_o),
    .dbg_free_ptr_o    (dbg_free_ptr_o)
  );

  // Clock / reset
  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    aresetn        = 1'b0;
    req_valid      = '0;
    free_valid     = '0;
    free_addr      = '0;
    mgr_req_ready  = 1'b0;
    mgr_req_addr   = '0;
    mgr_free_ready = 1'b0;
    mgr_full       = 1'b0;

    // Reset state
    repeat (2) tick();
    check("rst_used", 32'(used_count), 32'd0);
    check("rst_err", 32'(free_err), 32'd0);
    check("rst_mgr_req_valid", 32'(mgr_req_valid), 32'd0);
    check("rst_mgr_free_valid", 32'(mgr_free_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_free_ready", 32'(free_ready), 32'd0);
    check("rst_alloc_ptr", 32'(dbg_alloc_ptr_o), 32'd0);
    aresetn = 1'b1;
    tick();

    // Two requesters held high: alternate grants, one transfer per two cycles
    req_valid = 2'b11; mgr_req_ready = 1'b1; mgr_req_addr = 16'd5;
    settle();
    check("rr_idle_valid", 32'(mgr_req_valid), 32'd0);
    tick();
    check("rr_g0_valid", 32'(mgr_req_valid), 32'd1);
    check("rr_g0_ready", 32'(req_ready), 32'b01);
    check("rr_g0_addr", 32'(req_addr), 32'd5);
    check("rr_g0_used", 32'(used_count), 32'd0);
    tick();
    mgr_req_addr = 16'd6;
    settle();
    check("rr_gap_ready", 32'(req_ready), 32'd0);
    check("rr_used1", 32'(used_count), 32'd1);
    check("rr_ptr1", 32'(dbg_alloc_ptr_o), 32'd1);
    tick();
    check("rr_g1_ready", 32'(req_ready), 32'b10);
    check("rr_g1_addr", 32'(req_addr), 32'd6);
    tick();
    req_valid = 2'b00;
    settle();
    check("rr_used2", 32'(used_count), 32'd2);
    check("rr_ptr0", 32'(dbg_alloc_ptr_o), 32'd0);
    check("rr_idle_again", 32'(mgr_req_valid), 32'd0);

    // Manager full blocks a new grant
    mgr_full = 1'b1; req_valid = 2'b01; mgr_req_addr = 16'd7;
    settle();
    for (int i = 0; i < 2; i++) begin
      tick();
      check("full_valid", 32'(mgr_req_valid), 32'd0);
      check("full_ready", 32'(req_ready), 32'd0);
    end
    mgr_full = 1'b0;
    settle();
    check("unfull_same_cycle", 32'(mgr_req_valid), 32'd0);
    tick();
    check("unfull_valid", 32'(mgr_req_valid), 32'd1);
    check("unfull_ready", 32'(req_ready), 32'b01);
    check("unfull_addr", 32'(req_addr), 32'd7);
    tick();
    req_valid = 2'b00;
    settle();
    check("unfull_used3", 32'(used_count), 32'd3);

    // Grant to requester 1 abandoned before any transfer
    req_valid = 2'b10; mgr_req_ready = 1'b0;
    settle();
    tick();
    check("drop_state_grant", 32'(dbg_alloc_state_o), 32'd1);
    check("drop_valid", 32'(mgr_req_valid), 32'd1);
    check("drop_no_ready", 32'(req_ready), 32'd0);
    req_valid = 2'b00;
    settle();
    check("drop_valid_low", 32'(mgr_req_valid), 32'd0);
    check("drop_ready_low", 32'(req_ready), 32'd0);
    tick();
    check("drop_state_idle", 32'(dbg_alloc_state_o), 32'd0);
    check("drop_ptr_kept", 32'(dbg_alloc_ptr_o), 32'd1);
    check("drop_used", 32'(used_count), 32'd3);

    // Allocation and release in the same cycle; grant survives mgr_full
    req_valid = 2'b10; free_valid = 2'b01; free_addr = {16'h0000, 16'h0020};
    settle();
    tick();
    mgr_full = 1'b1;
    settle();
    check("both_req_valid", 32'(mgr_req_valid), 32'd1);
    check("both_free_valid", 32'(mgr_free_valid), 32'd1);
    check("both_free_addr", 32'(mgr_free_addr), 32'h20);
    check("both_wait_req_ready", 32'(req_ready), 32'd0);
    check("both_wait_free_ready", 32'(free_ready), 32'd0);
    tick();
    check("full_keeps_grant", 32'(mgr_req_valid), 32'd1);
    mgr_req_ready = 1'b1; mgr_free_ready = 1'b1; mgr_req_addr = 16'd9;
    settle();
    check("both_req_ready", 32'(req_ready), 32'b10);
    check("both_free_ready", 32'(free_ready), 32'b01);
    check("both_req_addr", 32'(req_addr), 32'd9);
    tick();
    req_valid = 2'b00; free_valid = 2'b00; mgr_full = 1'b0;
    settle();
    check("both_used_same", 32'(used_count), 32'd3);
    check("both_alloc_ptr", 32'(dbg_alloc_ptr_o), 32'd0);
    check("both_free_ptr", 32'(dbg_free_ptr_o), 32'd1);

    // Drain three nodes through alternating release grants
    free_valid = 2'b11; free_addr = {16'h0031, 16'h0030};
    settle();
    for (int k = 0; k < 3; k++) begin
      tick();
      check("drain_ready", 32'(free_ready), (k % 2 == 0) ? 32'b10 : 32'b01);
      check("drain_addr", 32'(mgr_free_addr), (k % 2 == 0) ? 32'h31 : 32'h30);
      tick();
      check("drain_used", 32'(used_count), 32'(2 - k));
    end
    free_valid = 2'b00;
    settle();
    check("drain_no_err", 32'(free_err), 32'd0);

    // Release with nothing allocated
    free_valid = 2'b10; free_addr = {16'h0010, 16'h0000};
    settle();
    tick();
    check("uf_valid", 32'(mgr_free_valid), 32'd1);
    check("uf_addr", 32'(mgr_free_addr), 32'h10);
    check("uf_ready", 32'(free_ready), 32'b10);
    tick();
    free_valid = 2'b00;
    settle();
    check("uf_used_zero", 32'(used_count), 32'd0);
    check("uf_err_set", 32'(free_err), 32'd1);
    repeat (3) tick();
    check("uf_err_sticky", 32'(free_err), 32'd1);

    // Async reset while holding a grant to requester 1
    req_valid = 2'b01; mgr_req_ready = 1'b1; mgr_req_addr = 16'h11;
    settle();
    repeat (2) tick();
    req_valid = 2'b10; mgr_req_ready = 1'b0;
    settle();
    tick();
    check("prerst_valid", 32'(mgr_req_valid), 32'd1);
    check("prerst_used", 32'(used_count), 32'd1);
    aresetn = 1'b0;
    settle();
    check("arst_valid", 32'(mgr_req_valid), 32'd0);
    check("arst_ready", 32'(req_ready), 32'd0);
    check("arst_used", 32'(used_count), 32'd0);
    check("arst_err", 32'(free_err), 32'd0);
    check("arst_state", 32'(dbg_alloc_state_o), 32'd0);
    tick();
    aresetn = 1'b1; req_valid = 2'b11; mgr_req_ready = 1'b1; mgr_req_addr = 16'h44;
    settle();
    tick();
    check("post_rst_ready", 32'(req_ready), 32'b01);
    check("post_rst_addr", 32'(req_addr), 32'h44);
    tick();
    req_valid = 2'b00;
    settle();
    check("post_rst_used", 32'(used_count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
